// File: rtl/gate_test_ctrl.sv
// Two-input gate tester: sweeps {in1,in0} through 00..11 for a number of loops and
// counts output mismatches. Optional sticky per-vector fail map under GATE_TEST_FAILMAP_EN.
module gate_test_ctrl #(
    parameter int STEP_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [STEP_W-1:0] step,
    input  logic [STEP_W-1:0] sample_dly,
    input  logic [3:0]        truth,
    input  logic [3:0]        loops,
    input  logic              dut_out,
    output logic              in0,
    output logic              in1,
    output logic              busy,
    output logic              done,
    output logic [STEP_W-1:0] err_cnt,
    output logic              pass,
    output logic [1:0]        dbg_state
`ifdef GATE_TEST_FAILMAP_EN
    ,
    output logic [3:0]        fail_map
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    localparam logic [STEP_W-1:0] ONE  = STEP_W'(1);
    localparam logic [STEP_W-1:0] ALL1 = '1;

    state_t            state_q;
    logic [STEP_W-1:0] step_q, dly_q, cnt_q, err_q;
    logic [3:0]        truth_q, loops_q, sweep_q;
    logic [1:0]        vec_q;
    logic              busy_q, done_q, pass_q;
`ifdef GATE_TEST_FAILMAP_EN
    logic [3:0]        fail_map_q;
`endif

    logic [STEP_W-1:0] s_eff_d, d_raw_d, d_eff_d, err_d;
    logic [3:0]        l_eff_d;
    logic              mismatch_d;

    // Effective run parameters are computed from the live inputs and latched on start.
    always_comb begin
        s_eff_d    = (step == '0) ? ONE : step;
        d_raw_d    = (sample_dly == '0) ? ONE : sample_dly;
        d_eff_d    = (d_raw_d > s_eff_d) ? s_eff_d : d_raw_d;
        l_eff_d    = (loops == 4'd0) ? 4'd1 : loops;
        mismatch_d = (cnt_q == dly_q) && (dut_out != truth_q[vec_q]);
        err_d      = (mismatch_d && (err_q != ALL1)) ? err_q + ONE : err_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            step_q     <= '0;
            dly_q      <= '0;
            cnt_q      <= '0;
            err_q      <= '0;
            truth_q    <= '0;
            loops_q    <= '0;
            sweep_q    <= '0;
            vec_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
`ifdef GATE_TEST_FAILMAP_EN
            fail_map_q <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q    <= RUN;
                        step_q     <= s_eff_d;
                        dly_q      <= d_eff_d;
                        truth_q    <= truth;
                        loops_q    <= l_eff_d;
                        cnt_q      <= ONE;
                        sweep_q    <= 4'd1;
                        vec_q      <= 2'd0;
                        err_q      <= '0;
                        pass_q     <= 1'b0;
                        busy_q     <= 1'b1;
`ifdef GATE_TEST_FAILMAP_EN
                        fail_map_q <= '0;
`endif
                    end
                end
                RUN: begin
                    // Abort wins over both the sample on this edge and FIN entry.
                    if (abort) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        pass_q  <= 1'b0;
                        vec_q   <= 2'd0;
                    end else begin
                        err_q <= err_d;
`ifdef GATE_TEST_FAILMAP_EN
                        if (mismatch_d) fail_map_q[vec_q] <= 1'b1;
`endif
                        if (cnt_q == step_q) begin
                            cnt_q <= ONE;
                            if (vec_q == 2'd3) begin
                                vec_q <= 2'd0;
                                if (sweep_q == loops_q) begin
                                    state_q <= FIN;
                                    busy_q  <= 1'b0;
                                    done_q  <= 1'b1;
                                    pass_q  <= (err_d == '0);
                                end else begin
                                    sweep_q <= sweep_q + 4'd1;
                                end
                            end else begin
                                vec_q <= vec_q + 2'd1;
                            end
                        end else begin
                            cnt_q <= cnt_q + ONE;
                        end
                    end
                end
                FIN: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    vec_q   <= 2'd0;
                end
            endcase
        end
    end

    assign in0       = vec_q[0];
    assign in1       = vec_q[1];
    assign busy      = busy_q;
    assign done      = done_q;
    assign err_cnt   = err_q;
    assign pass      = pass_q;
    assign dbg_state = state_q;
`ifdef GATE_TEST_FAILMAP_EN
    assign fail_map  = fail_map_q;
`endif

endmodule

// File: tb/tb_gate_test_ctrl.sv
// Bench for gate_test_ctrl: directed runs push expected results; a negedge monitor
// checks vectors while busy and compares the run outcome when busy falls.
module tb_gate_test_ctrl;

  localparam int EW = 38;  // {done, pass, err[7:0], fmap[3:0], len[15:0], s[7:0]}

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0, abort = 1'b0;
  logic [7:0] step = '0, sample_dly = '0;
  logic [3:0] truth = '0, loops = '0;
  int gate_mode = 0;  // 0 AND, 1 OR, 2 stuck-at-0
  logic dut_out;
  logic in0, in1, busy, done, pass;
  logic [7:0] err_cnt;
  logic [1:0] dbg_state;
`ifdef GATE_TEST_FAILMAP_EN
  logic [3:0] fail_map;
`endif

  logic start2 = 1'b0;
  logic in0_2, in1_2, busy2, done2, pass2;
  logic [3:0] err2;
  logic [1:0] dbg2;
`ifdef GATE_TEST_FAILMAP_EN
  logic [3:0] fail_map2;
`endif

  int checks = 0, errors = 0, done_seen = 0;
  logic [EW-1:0] exp_q[$];

  always #5 clk = ~clk;

  assign dut_out = (gate_mode == 0) ? (in0 & in1) :
                   (gate_mode == 1) ? (in0 | in1) : 1'b0;

  gate_test_ctrl #(.STEP_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .step(step),
    .sample_dly(sample_dly), .truth(truth), .loops(loops), .dut_out(dut_out),
    .in0(in0), .in1(in1), .busy(busy), .done(done), .err_cnt(err_cnt),
    .pass(pass), .dbg_state(dbg_state)
`ifdef GATE_TEST_FAILMAP_EN
    , .fail_map(fail_map)
`endif
  );

  gate_test_ctrl #(.STEP_W(4)) dut_sat (
    .clk(clk), .rst(rst), .start(start2), .abort(1'b0), .step(4'd1),
    .sample_dly(4'd1), .truth(4'hF), .loops(4'hF), .dut_out(1'b0),
    .in0(in0_2), .in1(in1_2), .busy(busy2), .done(done2), .err_cnt(err2),
    .pass(pass2), .dbg_state(dbg2)
`ifdef GATE_TEST_FAILMAP_EN
    , .fail_map(fail_map2)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic push_exp(input logic dn, input logic ps, input logic [7:0] er,
                          input logic [3:0] fm, input int len, input int s);
    exp_q.push_back({dn, ps, er, fm, 16'(len), 8'(s)});
  endtask

  // Returns at the negedge inside run cycle 1.
  task automatic issue(input logic [7:0] st, input logic [7:0] dl, input logic [3:0] tr,
                       input logic [3:0] lp, input int mode);
    @(negedge clk);
    step = st; sample_dly = dl; truth = tr; loops = lp; gate_mode = mode;
    rst = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain(input int bound);
    for (int i = 0; i < bound; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout actual=%0d expected=0", exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic abort_at(input int n);
    repeat (n - 1) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
  endtask

  // Monitor
  logic prev_busy = 1'b0;
  logic vec_bad = 1'b0;
  int len_cnt = 0;
  logic [EW-1:0] cur;
  int ev;

  always @(negedge clk) begin
    if (busy) begin
      len_cnt++;
      if (exp_q.size() == 0) vec_bad = 1'b1;
      else begin
        cur = exp_q[0];
        ev = ((len_cnt - 1) / int'(cur[7:0])) % 4;
        if ({in1, in0} != 2'(ev) || done || pass) vec_bad = 1'b1;
      end
    end else if (prev_busy) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_run", 1, 0);
      end else begin
        cur = exp_q.pop_front();
        chk("run_vectors", 32'(vec_bad), 0);
        chk("run_len", 32'(len_cnt), 32'(cur[23:8]));
        chk("end_done", 32'(done), 32'(cur[37]));
        chk("end_pass", 32'(pass), 32'(cur[36]));
        chk("end_err", 32'(err_cnt), 32'(cur[35:28]));
        chk("end_vec_zero", 32'({in1, in0}), 0);
`ifdef GATE_TEST_FAILMAP_EN
        chk("end_fail_map", 32'(fail_map), 32'(cur[27:24]));
`endif
      end
      len_cnt = 0;
      vec_bad = 1'b0;
    end
    if (done) done_seen++;
    prev_busy = busy;
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_pass", 32'(pass), 0);
    chk("rst_err", 32'(err_cnt), 0);
    chk("rst_vec", 32'({in1, in0}), 0);
    chk("rst_state", 32'(dbg_state), 0);

    // AND gate, truth 1000; start on first edge after reset release; re-start ignored
    push_exp(1, 1, 8'd0, 4'b0000, 20, 5);
    issue(8'd5, 8'd3, 4'b1000, 4'd1, 0);
    repeat (6) @(negedge clk);
    start = 1'b1; step = 8'd9;
    @(negedge clk);
    start = 1'b0;
    drain(100);
    repeat (3) @(negedge clk);
    chk("idle_pass_hold", 32'(pass), 1);

    // OR gate against AND truth, two sweeps
    push_exp(1, 0, 8'd4, 4'b0110, 24, 3);
    issue(8'd3, 8'd2, 4'b1000, 4'd2, 1);
    drain(100);

    // Zero parameters clamp to 1
    push_exp(1, 1, 8'd0, 4'b0000, 4, 1);
    issue(8'd0, 8'd0, 4'b1000, 4'd0, 0);
    drain(100);

    // Delay clamped to 4; abort on the sampling edge wins
    push_exp(0, 0, 8'd0, 4'b0000, 4, 4);
    issue(8'd4, 8'd9, 4'b1111, 4'd1, 1);
    abort_at(4);
    drain(100);

    // Abort at cycle 6 keeps the one mismatch from vector 00
    push_exp(0, 0, 8'd1, 4'b0001, 6, 4);
    issue(8'd4, 8'd9, 4'b1111, 4'd1, 1);
    abort_at(6);
    drain(100);
    repeat (2) @(negedge clk);
    chk("idle_err_hold", 32'(err_cnt), 1);

    // Reset during cycle 10, then a fresh run
    push_exp(0, 0, 8'd0, 4'b0000, 10, 2);
    issue(8'd2, 8'd1, 4'b1111, 4'd2, 1);
    repeat (9) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_err", 32'(err_cnt), 0);
    chk("midrst_vec", 32'({in1, in0}), 0);
    drain(10);
    push_exp(1, 1, 8'd0, 4'b0000, 8, 2);
    issue(8'd2, 8'd1, 4'b1000, 4'd1, 0);
    drain(100);

    // Stuck-at-0, truth 1111, 15 loops; step input changed mid-run
    push_exp(1, 0, 8'd60, 4'b1111, 1200, 20);
    issue(8'd20, 8'd10, 4'b1111, 4'd15, 2);
    repeat (100) @(negedge clk);
    step = 8'd3;
    drain(1500);

    // Saturation on a 4-bit counter: 60 mismatches clip to 15
    @(negedge clk);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (done2) break;
      @(negedge clk);
    end
    chk("sat_done", 32'(done2), 1);
    chk("sat_err", 32'(err2), 32'hF);
    chk("sat_pass", 32'(pass2), 0);

    repeat (3) @(negedge clk);
    chk("done_pulses", 32'(done_seen), 5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
